// File: rtl/fitness_pkg.sv
// Shared types and constants for the workout session controller.
package fitness_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_ALARM = 2'b11
  } sessState_t;

  localparam int HR_EMERG = 180;
  localparam int HR_WARN  = 150;

endpackage

// File: rtl/workout_session_ctrl_sec_tick_gen.sv
// Free-running divider that emits a one-cycle tick every TICK_DIV enabled cycles.
module sec_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == LAST);

  // Clear wins over enable; the count freezes when neither is asserted.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/workout_session_ctrl.sv
// Session FSM that samples heart rate once per second for the step calculator
// and raises an alarm after a run of emergency readings.
module workout_session_ctrl #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int HR_EMERG   = fitness_pkg::HR_EMERG,
  parameter int EMERG_HOLD = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start_btn,
  input  logic        i_pause_btn,
  input  logic        i_stop_btn,
  input  logic [7:0]  i_hr_input,
  input  logic        i_hr_valid,
  output logic        o_sample_valid,
  output logic        o_calc_rst,
  output logic [7:0]  o_hr_latched,
  output logic [1:0]  o_state,
  output logic [15:0] o_session_secs,
  output logic        o_alarm
);

  import fitness_pkg::*;

  localparam logic [7:0] HR_LIMIT = 8'(HR_EMERG);
  localparam logic [7:0] HOLD     = 8'(EMERG_HOLD);

  sessState_t  r_state, w_nextState;
  logic        w_tick, w_tickDone, w_emit, w_start, w_alarmTrip;
  logic [7:0]  w_sampleHr, w_emergNext;
  logic [7:0]  r_hrCap, r_hrLatched, r_emergCnt;
  logic        r_sticky, r_sampleValid, r_calcRst;
  logic [15:0] r_secs;

  sec_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (r_state == ST_RUN),
    .i_clr  ((r_state == ST_IDLE) || (r_state == ST_ALARM)),
    .o_tick (w_tick)
  );

  // A stop in the tick cycle throws the whole second away.
  assign w_tickDone  = w_tick && !i_stop_btn;
  assign w_emit      = w_tickDone && (r_sticky || i_hr_valid);
  assign w_sampleHr  = i_hr_valid ? i_hr_input : r_hrCap;
  assign w_emergNext = (w_sampleHr > HR_LIMIT)
                       ? ((r_emergCnt == 8'hFF) ? r_emergCnt : r_emergCnt + 8'd1)
                       : 8'd0;
  assign w_alarmTrip = w_emit && (w_emergNext >= HOLD);
  assign w_start     = (r_state == ST_IDLE) && (w_nextState == ST_RUN);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_nextState;
  end

  // Only the highest-priority request is considered; if it does not apply here it is dropped.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:  if (!i_stop_btn && !i_pause_btn && i_start_btn) w_nextState = ST_RUN;
      ST_RUN: begin
        if (i_stop_btn)       w_nextState = ST_IDLE;
        else if (w_alarmTrip) w_nextState = ST_ALARM;
        else if (i_pause_btn) w_nextState = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (i_stop_btn)       w_nextState = ST_IDLE;
        else if (i_pause_btn) w_nextState = ST_RUN;
      end
      ST_ALARM: if (i_stop_btn) w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_calcRst     <= 1'b0;
      r_sampleValid <= 1'b0;
      r_secs        <= '0;
      r_emergCnt    <= '0;
      r_sticky      <= 1'b0;
      r_hrCap       <= '0;
      r_hrLatched   <= '0;
    end else begin
      r_calcRst     <= w_start;
      r_sampleValid <= w_emit;
      if (w_start) begin
        r_secs     <= '0;
        r_emergCnt <= '0;
        r_sticky   <= 1'b0;
      end else begin
        if (w_tickDone && (r_secs != 16'hFFFF)) r_secs <= r_secs + 16'd1;
        if (w_emit) begin
          r_hrLatched <= w_sampleHr;
          r_emergCnt  <= w_emergNext;
          r_sticky    <= 1'b0;
        end else if ((r_state == ST_RUN) && i_hr_valid) begin
          r_sticky <= 1'b1;
        end
        if ((r_state == ST_RUN) && i_hr_valid) r_hrCap <= i_hr_input;
      end
    end
  end

  assign o_sample_valid = r_sampleValid;
  assign o_calc_rst     = r_calcRst;
  assign o_hr_latched   = r_hrLatched;
  assign o_state        = r_state;
  assign o_session_secs = r_secs;
  assign o_alarm        = (r_state == ST_ALARM);

endmodule

// File: tb/tb_workout_session_ctrl.sv
// Directed bench for workout_session_ctrl with a 4-cycle second and a 3-sample alarm hold.
module tb_workout_session_ctrl;
  import fitness_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        startBtn, pauseBtn, stopBtn, hrValid;
  logic [7:0]  hrIn;
  logic        sampleValid, calcRst, alarm;
  logic [7:0]  hrLatched;
  logic [1:0]  state;
  logic [15:0] sessionSecs;

  int nAsserts = 0;
  int nFail    = 0;
  int svCount;
  int crCount;

  always #5 clk = ~clk;

  workout_session_ctrl #(
    .TICK_DIV   (4),
    .HR_EMERG   (180),
    .EMERG_HOLD (3)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start_btn    (startBtn),
    .i_pause_btn    (pauseBtn),
    .i_stop_btn     (stopBtn),
    .i_hr_input     (hrIn),
    .i_hr_valid     (hrValid),
    .o_sample_valid (sampleValid),
    .o_calc_rst     (calcRst),
    .o_hr_latched   (hrLatched),
    .o_state        (state),
    .o_session_secs (sessionSecs),
    .o_alarm        (alarm)
  );

  // Drive one cycle of inputs, then sample just after the edge that consumed them.
  task automatic applyStimulus(input logic st, input logic pa, input logic sp,
                               input logic hv, input logic [7:0] hr);
    startBtn = st;
    pauseBtn = pa;
    stopBtn  = sp;
    hrValid  = hv;
    hrIn     = hr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Four cycles from counter 0 end on the tick edge.
  task automatic runSecond(input logic hv, input logic [7:0] hr);
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b0, 1'b0, hv, hr);
  endtask

  initial begin
    rst = 1'b1;
    startBtn = 1'b0; pauseBtn = 1'b0; stopBtn = 1'b0; hrValid = 1'b0; hrIn = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkOutput("rst_state", state, 2'b00);
    checkOutput("rst_sv", sampleValid, 1'b0);
    checkOutput("rst_secs", sessionSecs, 16'd0);
    checkOutput("rst_alarm", alarm, 1'b0);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 8'd0);
    checkOutput("idle_state", state, 2'b00);

    $display("[TB] steady hr=100 for three seconds");
    applyStimulus(1, 0, 0, 0, 8'd0);
    checkOutput("start_state", state, 2'b01);
    checkOutput("start_calc_rst", calcRst, 1'b1);
    svCount = 0;
    crCount = 1;
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(0, 0, 0, 1, 8'd100);
      checkOutput($sformatf("run_sv_%0d", i), sampleValid, (i % 4 == 0) ? 1'b1 : 1'b0);
      if (sampleValid) svCount++;
      if (calcRst) crCount++;
    end
    checkOutput("run_sv_count", svCount, 3);
    checkOutput("run_cr_count", crCount, 1);
    checkOutput("run_hr_latched", hrLatched, 8'd100);
    checkOutput("run_secs", sessionSecs, 16'd3);
    applyStimulus(0, 0, 1, 0, 8'd0);
    checkOutput("stop_state", state, 2'b00);

    $display("[TB] pause and resume");
    applyStimulus(1, 0, 0, 0, 8'd0);
    applyStimulus(0, 0, 0, 1, 8'd90);
    applyStimulus(0, 1, 0, 1, 8'd90);
    checkOutput("pause_state", state, 2'b10);
    svCount = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 0, 1, 8'd200);
      if (sampleValid || state != 2'b10) svCount++;
    end
    checkOutput("pause_quiet", svCount, 0);
    checkOutput("pause_secs", sessionSecs, 16'd0);
    applyStimulus(0, 1, 0, 0, 8'd0);
    checkOutput("resume_state", state, 2'b01);
    applyStimulus(0, 0, 0, 0, 8'd0);
    checkOutput("resume_sv_early", sampleValid, 1'b0);
    applyStimulus(0, 0, 0, 0, 8'd0);
    checkOutput("resume_sv", sampleValid, 1'b1);
    checkOutput("resume_hr", hrLatched, 8'd90);
    checkOutput("resume_secs", sessionSecs, 16'd1);
    applyStimulus(0, 0, 1, 0, 8'd0);

    $display("[TB] three emergency samples");
    applyStimulus(1, 0, 0, 0, 8'd0);
    runSecond(1, 8'd185);
    checkOutput("emerg1_state", state, 2'b01);
    runSecond(1, 8'd185);
    checkOutput("emerg2_state", state, 2'b01);
    runSecond(1, 8'd185);
    checkOutput("emerg3_sv", sampleValid, 1'b1);
    checkOutput("emerg3_state", state, 2'b11);
    checkOutput("emerg3_alarm", alarm, 1'b1);
    applyStimulus(1, 1, 0, 1, 8'd185);
    checkOutput("alarm_ignore", state, 2'b11);
    checkOutput("alarm_secs_hold", sessionSecs, 16'd3);
    applyStimulus(0, 0, 1, 0, 8'd0);
    checkOutput("alarm_stop_state", state, 2'b00);
    checkOutput("alarm_stop_alarm", alarm, 1'b0);

    $display("[TB] interrupted emergency run");
    applyStimulus(1, 0, 0, 0, 8'd0);
    runSecond(1, 8'd185);
    runSecond(1, 8'd185);
    runSecond(1, 8'(HR_WARN));
    checkOutput("break_hr", hrLatched, 8'd150);
    runSecond(1, 8'd185);
    runSecond(1, 8'd185);
    checkOutput("break_sv", sampleValid, 1'b1);
    checkOutput("break_state", state, 2'b01);
    checkOutput("break_alarm", alarm, 1'b0);
    applyStimulus(0, 0, 1, 0, 8'd0);

    $display("[TB] silent second and stop on tick");
    applyStimulus(1, 0, 0, 0, 8'd0);
    runSecond(1, 8'd120);
    checkOutput("silent_pre_sv", sampleValid, 1'b1);
    runSecond(0, 8'd0);
    checkOutput("silent_sv", sampleValid, 1'b0);
    checkOutput("silent_secs", sessionSecs, 16'd2);
    checkOutput("silent_hr", hrLatched, 8'd120);
    for (int c = 0; c < 3; c++) applyStimulus(0, 0, 0, 1, 8'd130);
    applyStimulus(0, 0, 1, 1, 8'd130);
    checkOutput("stoptick_state", state, 2'b00);
    checkOutput("stoptick_sv", sampleValid, 1'b0);
    checkOutput("stoptick_secs", sessionSecs, 16'd2);
    checkOutput("stoptick_hr", hrLatched, 8'd120);
    applyStimulus(0, 0, 0, 0, 8'd0);
    checkOutput("stoptick_sv_after", sampleValid, 1'b0);
    applyStimulus(1, 0, 1, 0, 8'd0);
    checkOutput("startstop_state", state, 2'b00);
    checkOutput("startstop_calc_rst", calcRst, 1'b0);

    $display("[TB] reset right after a tick");
    applyStimulus(1, 0, 0, 0, 8'd0);
    runSecond(1, 8'd77);
    checkOutput("pre_rst_sv", sampleValid, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_sv", sampleValid, 1'b0);
    checkOutput("midrst_state", state, 2'b00);
    checkOutput("midrst_hr", hrLatched, 8'd0);
    checkOutput("midrst_secs", sessionSecs, 16'd0);
    checkOutput("midrst_alarm", alarm, 1'b0);
    checkOutput("midrst_calc_rst", calcRst, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(0, 0, 0, 1, 8'd77);
    checkOutput("postrst_state", state, 2'b00);
    checkOutput("postrst_sv", sampleValid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule

// File: doc/workout_session_ctrl.md
WORKOUT_SESSION_CTRL -- requirements
Module: workout_session_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50_000_000, meaning clk cycles per 1 s sample tick.
REQ-002 SHALL have parameter HR_EMERG, default 180, meaning the heart-rate threshold; a sample strictly above it counts as emergency.
REQ-003 SHALL have parameter EMERG_HOLD, default 3, meaning the number of consecutive emergency samples that raises the alarm.
REQ-004 SHALL have clk, input, 1, the single system clock; all logic on posedge clk.
REQ-005 SHALL have rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have start_btn, input, 1, one-cycle start request.
REQ-007 SHALL have pause_btn, input, 1, one-cycle pause/resume toggle request.
REQ-008 SHALL have stop_btn, input, 1, one-cycle stop request.
REQ-009 SHALL have hr_input, input, 8, heart-rate sensor value in bpm.
REQ-010 SHALL have hr_valid, input, 1, qualifier meaning hr_input is valid this cycle.
REQ-011 SHALL have sample_valid, output, 1, one-cycle strobe to the step calculator valid_input.
REQ-012 SHALL have calc_rst, output, 1, one-cycle clear strobe to the calculator datapath.
REQ-013 SHALL have hr_latched, output, 8, the last valid heart rate captured for the current sample.
REQ-014 SHALL have state, output, 2, encoded FSM state.
REQ-015 SHALL have session_secs, output, 16, elapsed running seconds.
REQ-016 SHALL have alarm, output, 1, emergency indicator.

Function
REQ-017 FSM SHALL have states IDLE=00, RUN=01, PAUSE=10 and ALARM=11.
REQ-018 Request priority SHALL be stop_btn > pause_btn > start_btn, with at most one transition per cycle.
REQ-019 IDLE SHALL go to RUN on start_btn; that transition SHALL pulse calc_rst for exactly 1 cycle and clear session_secs, the tick counter, the emergency counter and the sticky valid flag.
REQ-020 RUN SHALL go to PAUSE on pause_btn; PAUSE SHALL go to RUN on pause_btn; RUN or PAUSE SHALL go to IDLE on stop_btn.
REQ-021 ALARM SHALL go to IDLE only on stop_btn; pause_btn and start_btn SHALL be ignored in ALARM and in any other state not listed above.
REQ-022 The tick counter SHALL count 0..TICK_DIV-1 only in RUN, hold its value in PAUSE, and clear in IDLE and ALARM.
REQ-023 A tick SHALL occur in the RUN cycle where counter==TICK_DIV-1, and the counter SHALL wrap to 0.
REQ-024 In RUN, every cycle with hr_valid=1 SHALL load hr_input into a capture register and set the sticky valid flag.
REQ-025 On a tick, session_secs SHALL increment and saturate at 65535.
REQ-026 On a tick with the sticky flag set, hr_latched SHALL be updated from the capture register and sample_valid SHALL go high in the next cycle (latency 1) for exactly 1 cycle; the sticky flag SHALL then clear.
REQ-027 On a tick with the sticky flag clear, sample_valid SHALL stay low and the emergency counter SHALL hold.
REQ-028 If hr_valid is high in the tick cycle itself, that hr_input SHALL be the value used for the sample.
REQ-029 On each emitted sample, the emergency counter SHALL increment if the value > HR_EMERG and clear otherwise.
REQ-030 When the emergency counter reaches EMERG_HOLD, the FSM SHALL enter ALARM in the same cycle the final sample_valid is asserted.
REQ-031 alarm SHALL be 1 exactly while state==ALARM.
REQ-032 stop_btn in a tick cycle SHALL discard the tick: no sample_valid and no session_secs increment.
REQ-033 pause_btn in a tick cycle SHALL let the tick complete first, then enter PAUSE.
REQ-034 session_secs SHALL hold in PAUSE and ALARM and clear only on IDLE->RUN.

Reset
REQ-035 rst SHALL asynchronously force state=IDLE, sample_valid=0, calc_rst=0, hr_latched=0, session_secs=0, alarm=0, and clear all internal counters and flags.
REQ-036 rst asserted mid-sample SHALL suppress any pending sample_valid.

Structure
REQ-037 Package fitness_pkg SHALL hold the state typedef/encoding and the default HR_EMERG and HR_WARN constants.
REQ-038 The one sub-module SHALL be sec_tick_gen, a TICK_DIV counter with enable/clear that outputs tick.
REQ-039 The datapath connection SHALL be sample_valid->valid_input, hr_latched->hr_input and calc_rst OR rst->calculator rst.

Verification (TICK_DIV=4, EMERG_HOLD=3)
REQ-040 Bench SHALL cover: start, then hr_valid=1 with hr=100 every cycle for 12 cycles -> calc_rst one pulse, 3 sample_valid pulses spaced 4 cycles apart each 1 cycle after the tick, hr_latched=100, session_secs=3.
REQ-041 Bench SHALL cover: RUN, pause at counter=2 held 10 cycles, then resume -> no sample_valid during PAUSE; next tick 2 cycles after resume.
REQ-042 Bench SHALL cover: three consecutive samples of hr=185 -> state=11 and alarm=1 on the 3rd sample_valid; a 2-185, 1-150, 2-185 pattern SHALL NOT alarm.
REQ-043 Bench SHALL cover: no hr_valid for one second -> tick with no sample_valid, session_secs still increments.
REQ-044 Bench SHALL cover: stop_btn coincident with a tick -> no sample_valid, session_secs unchanged, state=IDLE; and start and stop in the same cycle in IDLE -> stays IDLE.
REQ-045 Bench SHALL cover: rst pulse one cycle after a tick -> sample_valid=0 immediately, all outputs at reset values.
